// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types for the MIPS fetch queue.
// Holds the fetch FSM state, the PC step and the {pc, instr} entry.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// mips_fetch_fifo: synchronous DEPTH-entry FIFO, W bits per entry.
// Ports: clk, rst_n, push_i/data_i, pop_i, flush_i -> data_o, count_o, empty_o, full_o.
module mips_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO can still take a write when the head leaves this cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: sequential instruction fetch with a {pc, instr} queue and redirect flush.
// Ports: clk, reset (async, active-low), imem_req_*/imem_rsp_* memory channel,
//   redirect_valid/redirect_pc from the core, fq_* head entry to the core, fetch_error sticky.
// Define MIPS_FETCH_BYPASS_EN to forward a response straight to fq_* when the queue is empty.
module mips_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fq_valid,
  input  logic        fq_ready,
  output logic [31:0] fq_pc,
  output logic [31:0] fq_instr,
  output logic        fetch_error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_S = (CW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          err_q, err_d;

  logic          hs;
  logic          redir;
  logic          redir_ok;
  logic          redir_bad;
  logic          keep_rsp;
  logic          byp;
  logic          consume;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  logic          q_full;
  logic [CW-1:0] q_cnt;
  entry_t        q_head;
  entry_t        q_in;
  logic [CW:0]   sum;

  logic [31:0]   trk_pc;
  logic [CW-1:0] trk_cnt;
  logic          trk_empty;
  logic          trk_full;

  assign hs        = imem_req_valid & imem_req_ready;
  assign redir     = redirect_valid & (state_q != HALT);
  assign redir_ok  = redir & (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redir & (redirect_pc[1:0] != 2'b00);

  // Stale responses (pending drops, redirect cycle, halted) never reach the queue.
  assign keep_rsp = imem_rsp_valid & (state_q == FETCH)
                  & ~redir & (drop_q == '0);

`ifdef MIPS_FETCH_BYPASS_EN
  assign byp = keep_rsp & q_empty;
`else
  assign byp = 1'b0;
`endif

  assign fq_valid = ~q_empty | byp;
  assign fq_pc    = ~q_empty ? q_head.pc
                  : (byp ? trk_pc : 32'h0);
  assign fq_instr = ~q_empty ? q_head.instr
                  : (byp ? imem_rsp_data : 32'h0);

  assign consume = fq_valid & fq_ready & ~redir;
  assign q_pop   = consume & ~q_empty;
  assign q_push  = keep_rsp & ~(byp & fq_ready);
  assign q_in    = '{pc: trk_pc, instr: imem_rsp_data};

  // Queued plus in-flight never exceeds DEPTH; a same-cycle pop frees one slot.
  assign sum = {1'b0, q_cnt} + {1'b0, out_q};
  assign imem_req_valid = (state_q == FETCH) & ((sum < DEPTH_S) | consume);
  assign imem_req_addr  = addr_q;
  assign fetch_error    = err_q;

  mips_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (q_push),
    .data_i  (q_in),
    .pop_i   (q_pop),
    .flush_i (redir),
    .data_o  (q_head),
    .count_o (q_cnt),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // Remembers the PC of every accepted request, in order, to tag its response.
  mips_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (hs),
    .data_i  (addr_q),
    .pop_i   (imem_rsp_valid),
    .flush_i (1'b0),
    .data_o  (trk_pc),
    .count_o (trk_cnt),
    .empty_o (trk_empty),
    .full_o  (trk_full)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    out_d   = out_q + CW'(hs) - CW'(imem_rsp_valid);
    drop_d  = drop_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (hs) addr_d = addr_q + PC_STEP;
    if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
    unique case (1'b1)
      redir_ok: begin
        addr_d = redirect_pc;
        drop_d = out_d;
      end
      redir_bad: begin
        state_d = HALT;
        err_d   = 1'b1;
        drop_d  = out_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

endmodule
